// File: rtl/dmni_ni_ctrl_pkg.sv
// dmni_ni_ctrl_pkg: register map, BrLite/Hermes types and IRQ bit indices for the DMNI control block.
package dmni_ni_ctrl_pkg;
  typedef enum logic [7:0] {
    DMNI_STATUS                 = 8'h00,
    DMNI_IRQ_STATUS             = 8'h01,
    DMNI_IRQ_MASK               = 8'h02,
    DMNI_IRQ_ACK                = 8'h03,
    DMNI_HERMES_SIZE            = 8'h04,
    DMNI_HERMES_SIZE_2          = 8'h05,
    DMNI_HERMES_ADDRESS         = 8'h06,
    DMNI_HERMES_ADDRESS_2       = 8'h07,
    DMNI_HERMES_OP              = 8'h08,
    DMNI_HERMES_START           = 8'h09,
    DMNI_HERMES_FLITS_AVAILABLE = 8'h0A,
    DMNI_RELEASE_PERIPHERAL     = 8'h0B,
    DMNI_BR_SERVICE             = 8'h0C,
    DMNI_BR_KSVC                = 8'h0D,
    DMNI_BR_SEQ_TARGET          = 8'h0E,
    DMNI_BR_PRODUCER            = 8'h0F,
    DMNI_BR_PAYLOAD             = 8'h10,
    DMNI_BR_START               = 8'h11,
    DMNI_BR_SVC_SERVICE         = 8'h12,
    DMNI_BR_SVC_PRODUCER        = 8'h13,
    DMNI_BR_SVC_PAYLOAD         = 8'h14,
    DMNI_BR_SVC_POP             = 8'h15,
    DMNI_BR_MON_CLEAR           = 8'h16,
    DMNI_BR_MON_PTR_BASE        = 8'h20
  } dmni_mmr_t;
  typedef enum logic {
    HERMES_OPERATION_SEND    = 1'b0,
    HERMES_OPERATION_RECEIVE = 1'b1
  } hermes_op_t;
  typedef struct packed {
    logic [7:0]  service;
    logic        ksvc;
    logic [15:0] seq_target;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;
  typedef struct packed {
    logic [7:0]  service;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;
  typedef enum logic {TX_IDLE, TX_REQ} tx_state_t;
  localparam int IRQ_HERMES_RX  = 0;
  localparam int IRQ_BR_SVC     = 1;
  localparam int IRQ_TX_DRAINED = 2;
  localparam int IRQ_START_REJ  = 3;
  localparam int STATUS_TX_OVF  = 7;
endpackage

// File: rtl/dmni_br_tx_fifo.sv
// dmni_br_tx_fifo: synchronous FIFO of BrLite outgoing entries; a push on a full queue is taken only alongside a pop.
module dmni_br_tx_fifo
  import dmni_ni_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  brlite_out_t              din,
  output brlite_out_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  brlite_out_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign head  = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(wr) - (AW + 1)'(rd);
    end
  end
endmodule

// File: rtl/dmni_ni_ctrl.sv
// dmni_ni_ctrl: DMNI control/status registers with Hermes start gating, maskable sticky IRQs,
// a queued BrLite transmitter and monitor pointer table.
module dmni_ni_ctrl
  import dmni_ni_ctrl_pkg::*;
#(
  parameter int HERMES_FLIT_SIZE = 32,
  parameter int N_MON            = 2,
  parameter int BR_TX_DEPTH      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        irq_o,
  input  logic                        cfg_en_i,
  input  logic                        cfg_we_i,
  input  dmni_mmr_t                   cfg_addr_i,
  input  logic [31:0]                 cfg_data_i,
  output logic [31:0]                 cfg_data_o,
  output logic                        release_peripheral_o,
  input  logic                        hermes_send_active_i,
  input  logic                        hermes_receive_active_i,
  input  logic                        hermes_receive_available_i,
  input  logic [HERMES_FLIT_SIZE-1:0] hermes_receive_flits_available_i,
  output logic                        hermes_start_o,
  output hermes_op_t                  hermes_operation_o,
  output logic [31:0]                 hermes_size_o,
  output logic [31:0]                 hermes_size_2_o,
  output logic [31:0]                 hermes_address_o,
  output logic [31:0]                 hermes_address_2_o,
  output logic                        br_mon_clear_o,
  input  logic                        br_mon_clear_ack_i,
  output logic [31:0]                 br_mon_task_clear_o,
  output logic [31:0]                 br_mon_ptrs_o [N_MON],
  input  logic                        br_svc_rx_i,
  output logic                        br_svc_ack_o,
  input  brlite_svc_t                 br_svc_data_i,
  input  logic                        br_local_busy_i,
  output logic                        br_req_o,
  input  logic                        br_ack_i,
  output brlite_out_t                 br_data_o
);
  localparam int CW = $clog2(BR_TX_DEPTH) + 1;
  tx_state_t tx_state;
  brlite_out_t stage, tx_head;
  logic [CW-1:0] tx_count;
  logic [3:0] irq_mask, irq_src;
  logic [7:0] ack_clr;
  logic [3:0] mon_idx;
  logic wr, tx_full, tx_empty, tx_pop, br_push, push_ok, start_req, engine_busy;
  logic drained_q, rejected_q, tx_overflow, mon_hit;
  assign wr          = cfg_en_i && cfg_we_i;
  assign ack_clr     = (wr && cfg_addr_i == DMNI_IRQ_ACK) ? cfg_data_i[7:0] : 8'h0;
  assign engine_busy = hermes_operation_o == HERMES_OPERATION_SEND ? hermes_send_active_i : hermes_receive_active_i;
  assign start_req   = wr && cfg_addr_i == DMNI_HERMES_START && cfg_data_i[0];
  assign br_push     = wr && cfg_addr_i == DMNI_BR_START && cfg_data_i[0];
  assign tx_pop      = tx_state == TX_REQ && br_ack_i;
  assign push_ok     = br_push && (!tx_full || tx_pop);
  assign irq_src     = {rejected_q, drained_q, br_svc_rx_i, hermes_receive_available_i};
  assign irq_o       = |(irq_src & irq_mask);
  assign mon_idx     = cfg_addr_i[3:0];
  assign mon_hit     = cfg_addr_i[7:4] == DMNI_BR_MON_PTR_BASE[7:4];
  dmni_br_tx_fifo #(.DEPTH(BR_TX_DEPTH)) u_fifo (
    .clk(clk_i), .rst(rst_i), .push(br_push), .pop(tx_pop), .din(stage),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  always_comb begin
    case (cfg_addr_i)
      DMNI_STATUS:                 cfg_data_o = {16'h0, 8'(tx_count), tx_overflow, tx_empty, tx_full,
                                                 release_peripheral_o, br_mon_clear_o, br_local_busy_i,
                                                 hermes_receive_active_i, hermes_send_active_i};
      DMNI_IRQ_STATUS:             cfg_data_o = {28'h0, irq_src};
      DMNI_IRQ_MASK:               cfg_data_o = {28'h0, irq_mask};
      DMNI_HERMES_FLITS_AVAILABLE: cfg_data_o = 32'(hermes_receive_flits_available_i);
      DMNI_BR_SVC_SERVICE:         cfg_data_o = {24'h0, br_svc_data_i.service};
      DMNI_BR_SVC_PRODUCER:        cfg_data_o = {16'h0, br_svc_data_i.producer};
      DMNI_BR_SVC_PAYLOAD:         cfg_data_o = br_svc_data_i.payload;
      default:                     cfg_data_o = '0;
    endcase
    for (int i = 0; i < N_MON; i++) if (mon_hit && mon_idx == 4'(i)) cfg_data_o = br_mon_ptrs_o[i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      release_peripheral_o <= 1'b0;
      hermes_start_o       <= 1'b0;
      hermes_operation_o   <= HERMES_OPERATION_SEND;
      hermes_size_o        <= '0;
      hermes_size_2_o      <= '0;
      hermes_address_o     <= '0;
      hermes_address_2_o   <= '0;
      irq_mask             <= 4'h3;
      drained_q            <= 1'b0;
      rejected_q           <= 1'b0;
      tx_overflow          <= 1'b0;
      stage                <= '0;
      br_svc_ack_o         <= 1'b0;
      br_mon_clear_o       <= 1'b0;
      br_mon_task_clear_o  <= '0;
      for (int i = 0; i < N_MON; i++) br_mon_ptrs_o[i] <= '0;
      tx_state             <= TX_IDLE;
      br_req_o             <= 1'b0;
      br_data_o            <= '0;
    end else begin
      if (wr && cfg_addr_i == DMNI_RELEASE_PERIPHERAL) release_peripheral_o <= cfg_data_i[0];
      if (wr && cfg_addr_i == DMNI_HERMES_SIZE)        hermes_size_o        <= cfg_data_i;
      if (wr && cfg_addr_i == DMNI_HERMES_SIZE_2)      hermes_size_2_o      <= cfg_data_i;
      if (wr && cfg_addr_i == DMNI_HERMES_ADDRESS)     hermes_address_o     <= cfg_data_i;
      if (wr && cfg_addr_i == DMNI_HERMES_ADDRESS_2)   hermes_address_2_o   <= cfg_data_i;
      if (wr && cfg_addr_i == DMNI_HERMES_OP)          hermes_operation_o   <= hermes_op_t'(cfg_data_i[0]);
      if (wr && cfg_addr_i == DMNI_IRQ_MASK)           irq_mask             <= cfg_data_i[3:0];
      if (wr && cfg_addr_i == DMNI_BR_SERVICE)         stage.service        <= cfg_data_i[7:0];
      if (wr && cfg_addr_i == DMNI_BR_KSVC)            stage.ksvc           <= cfg_data_i[0];
      if (wr && cfg_addr_i == DMNI_BR_SEQ_TARGET)      stage.seq_target     <= cfg_data_i[15:0];
      if (wr && cfg_addr_i == DMNI_BR_PRODUCER)        stage.producer       <= cfg_data_i[15:0];
      if (wr && cfg_addr_i == DMNI_BR_PAYLOAD)         stage.payload        <= cfg_data_i;
      hermes_start_o <= start_req && !engine_busy;
      // sticky sources: a set in the same cycle as the clear wins
      rejected_q  <= (start_req && engine_busy) || (rejected_q && !ack_clr[IRQ_START_REJ]);
      drained_q   <= (tx_pop && tx_count == CW'(1) && !push_ok) || (drained_q && !ack_clr[IRQ_TX_DRAINED]);
      tx_overflow <= (br_push && !push_ok) || (tx_overflow && !ack_clr[STATUS_TX_OVF]);
      br_svc_ack_o <= wr && cfg_addr_i == DMNI_BR_SVC_POP && cfg_data_i[0] && !br_svc_ack_o;
      if (br_mon_clear_ack_i) br_mon_clear_o <= 1'b0;
      else if (wr && cfg_addr_i == DMNI_BR_MON_CLEAR && !br_mon_clear_o) begin
        br_mon_clear_o      <= 1'b1;
        br_mon_task_clear_o <= cfg_data_i;
      end
      for (int i = 0; i < N_MON; i++) if (wr && mon_hit && mon_idx == 4'(i)) br_mon_ptrs_o[i] <= cfg_data_i;
      if (tx_state == TX_IDLE) begin
        if (!tx_empty && !br_local_busy_i) begin
          br_data_o <= tx_head;
          br_req_o  <= 1'b1;
          tx_state  <= TX_REQ;
        end
      end else if (br_ack_i) begin
        br_req_o <= 1'b0;
        tx_state <= TX_IDLE;
      end
    end
  end
endmodule
